// File: rtl/piso_stream.sv
// Parallel-in/serial-out lane converter with valid/ready on both sides.
// Define PISO_MSB_FIRST_EN to emit the highest valid lane first.
module piso_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 8,
  parameter int LEN_W      = $clog2(NUM_LANES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0]                in_len,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic                            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [LEN_W-1:0] FULL = LEN_W'(NUM_LANES);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sr_q [NUM_LANES];
  logic [DATA_WIDTH-1:0]   sr_d [NUM_LANES];
  logic [DATA_WIDTH-1:0]   load [NUM_LANES];
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [LEN_W-1:0]        eff_len;
  logic                    accept;
  logic                    xfer;

  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid;
  assign out_data  = sr_q[0];
  assign out_last  = out_valid && (rem_q == LEN_W'(1));
  assign in_ready  = !rst && (!out_valid || (out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // Zero and out-of-range lengths both mean a full word.
  assign eff_len = ((in_len == '0) || (in_len > FULL)) ? FULL : in_len;

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      load[k] = '0;
    end
`ifdef PISO_MSB_FIRST_EN
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k < int'(eff_len)) begin
        load[k] = in_data[(int'(eff_len) - 1 - k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`else
    for (int k = 0; k < NUM_LANES; k++) begin
      load[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sr_d    = sr_q;
    if (accept) begin
      sr_d    = load;
      rem_d   = eff_len;
      state_d = SHIFT;
    end else if (xfer) begin
      for (int k = 0; k < NUM_LANES - 1; k++) begin
        sr_d[k] = sr_q[k+1];
      end
      sr_d[NUM_LANES-1] = '0;
      rem_d = rem_q - LEN_W'(1);
      if (out_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sr_q    <= sr_d;
    end
  end

endmodule
